// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster x/y counter with one-clk-delayed sync/blank decode aligned to the encoder's px_data
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CLK_DIV = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        px_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_B = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_E = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_B = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_E = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  logic [DW-1:0] div_cnt;
  logic adv, hs_n, vs_n, vo_n;
  always_comb begin
    adv = en && (div_cnt == DIV_LAST);
    hs_n = (x >= HS_B && x < HS_E) ? SYNC_POL : ~SYNC_POL;
    vs_n = (y >= VS_B && y < VS_E) ? SYNC_POL : ~SYNC_POL;
    vo_n = (x < HA) && (y < VA);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      x <= '0;
      y <= '0;
      px_tick <= 1'b0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      video_on <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= (adv || !en) ? '0 : div_cnt + 1'b1;
      x <= adv ? (x == H_LAST ? '0 : x + 1'b1) : x;
      y <= (adv && x == H_LAST) ? (y == V_LAST ? '0 : y + 1'b1) : y;
      px_tick <= adv;
      hsync <= hs_n;
      vsync <= vs_n;
      video_on <= vo_n;
      // (0,0) right after a tick can only come from the frame wrap, never from reset
      frame_start <= px_tick && x == '0 && y == '0;
    end
  end
endmodule
